demux_rr_sequencer: RTL
=======================

// Module: demux_rr_sequencer
// PURPOSE
// Upstream driver for the 1:4 demux (demux14). Accepts words over a valid/ready
// handshake, picks the destination channel round-robin among enabled channels,
// and presents In/Sel to the demux until the target consumer takes the word.
// A per-item timeout drops words whose channel stalls.
// PARAMETERS
// WIDTH    1   data width of In_data / In (demux14 instance uses 1)
// TIMEOUT  16  max HOLD cycles before drop; 0 = never drop
// CNT_W    8   width of Xfer_cnt and Drop_cnt (wrap-around)
// PORTS
// clk       in   1      clock, rising edge
// rst       in   1      asynchronous, active-high reset
// In_valid  in   1      upstream word valid
// In_data   in   WIDTH  upstream word
// In_ready  out  1      sequencer can accept a word this cycle
// Ch_en     in   4      channel enable mask; bit i = demux Out[i] eligible
// Ch_ready  in   4      consumer i takes the word this cycle when Sel==i
// In        out  WIDTH  data to demux14.In (registered)
// Sel       out  2      channel select to demux14.Sel (registered)
// Out_valid out  1      In/Sel hold a live word
// Drop      out  1      1-cycle pulse: held word discarded on timeout
// Xfer_cnt  out  CNT_W  delivered-word count
// Drop_cnt  out  CNT_W  dropped-word count
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, ptr=0, In=0, Sel=0, Out_valid=0,
//   Drop=0, Xfer_cnt=0, Drop_cnt=0, wait_cnt=0. A held word is lost.
// - In_ready = (state==IDLE) & |Ch_en  (combinational, no dependence on In_valid).
// - FSM, two states:
//   IDLE: on In_valid & In_ready: In<=In_data; Sel<=first enabled channel
//     searching ptr, ptr+1, ... mod 4; Out_valid<=1; wait_cnt<=0; ->HOLD.
//     Latency accept -> Out_valid: 1 cycle.
//   HOLD: transfer when Ch_ready[Sel]==1: Out_valid<=0, ptr<=Sel+1 mod 4
//     (3 wraps to 0), Xfer_cnt++, ->IDLE.
//     Else if TIMEOUT!=0 and wait_cnt==TIMEOUT-1: Out_valid<=0, Drop<=1,
//     ptr<=Sel+1 mod 4, Drop_cnt++, ->IDLE. Else wait_cnt++.
//     Transfer wins over timeout on the same cycle.
// - Peak throughput: one word per 2 cycles (no accept while in HOLD).
// - In and Sel are stable for the entire HOLD. In keeps its last value in IDLE.
// - Ch_en changes in HOLD do not move Sel; the word goes to the committed
//   channel even if its enable bit is now 0. Ch_en is sampled only at accept.
// - Ch_en==0: In_ready=0 and the FSM stays in IDLE.
// - Ch_ready bits other than Sel are ignored.
// - Counters wrap 2^CNT_W-1 -> 0 silently.
// TESTING
// 1 Reset: rst=1 mid-HOLD -> Out_valid=0, Sel=0, counters=0, In_ready=1
//   (Ch_en=4'hF) on the first cycle after release.
// 2 Round-robin: Ch_en=F, Ch_ready=F, 5 words -> Sel=0,1,2,3,0; Xfer_cnt=5;
//   Out_valid high 1 cycle per word.
// 3 Mask skip: Ch_en=4'b1010, Ch_ready=F, 4 words -> Sel=1,3,1,3.
// 4 Stall/timeout: TIMEOUT=16, Ch_ready=0 -> Drop pulses 16 cycles after
//   Out_valid rises; Drop_cnt=1; next word goes to Sel+1.
// 5 Edge race: Ch_ready[Sel] rises on the timeout cycle -> Xfer_cnt++,
//   Drop stays 0.
// 6 Hold-stable: drop Ch_en[Sel] during HOLD -> In/Sel unchanged and the word
//   is delivered; Ch_en=0 in IDLE -> In_ready=0 and no accept.

Source files
------------

// File: rtl/demux_rr_sequencer.sv
// rtl/demux_rr_sequencer.sv - round-robin upstream sequencer for a 1:4 demux
//
// Accepts words over In_valid/In_ready, commits each to the next enabled
// channel in round-robin order, and holds In/Sel steady until that channel's
// consumer takes the word or the hold times out.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   In_valid, In_data   upstream word and its valid
//   In_ready            sequencer can accept this cycle (IDLE and any enable)
//   Ch_en               channel enable mask, sampled only at accept
//   Ch_ready            per-channel consumer ready; only Ch_ready[Sel] matters
//   In, Sel             registered data/select presented to the demux
//   Out_valid           In/Sel hold a live word
//   Drop                one-cycle pulse when a held word is discarded
//   Xfer_cnt, Drop_cnt  wrap-around delivered/dropped word counters

module demux_rr_sequencer #(
  parameter int WIDTH   = 1,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_valid,
  input  logic [WIDTH-1:0] In_data,
  output logic             In_ready,
  input  logic [3:0]       Ch_en,
  input  logic [3:0]       Ch_ready,
  output logic [WIDTH-1:0] In,
  output logic [1:0]       Sel,
  output logic             Out_valid,
  output logic             Drop,
  output logic [CNT_W-1:0] Xfer_cnt,
  output logic [CNT_W-1:0] Drop_cnt
);

  // wait_cnt only needs to reach TIMEOUT-1; with TIMEOUT==0 it just free-runs.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [WIDTH-1:0] in_n;
  logic [1:0]       sel_n;
  logic             ov_n;
  logic             drop_n;
  logic [CNT_W-1:0] xfer_n, dropc_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;

  logic [1:0] pick;
  logic [1:0] cand;
  logic       found;

  assign In_ready = (state == IDLE) && (Ch_en != 4'b0000);

  // First enabled channel starting at ptr and wrapping modulo 4.
  always_comb begin
    pick  = ptr;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && Ch_en[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    in_n    = In;
    sel_n   = Sel;
    ov_n    = Out_valid;
    drop_n  = 1'b0;
    xfer_n  = Xfer_cnt;
    dropc_n = Drop_cnt;
    wait_n  = wait_cnt;
    case (state)
      IDLE: begin
        if (In_valid && In_ready) begin
          in_n    = In_data;
          sel_n   = pick;
          ov_n    = 1'b1;
          wait_n  = '0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        // Delivery is checked first so it wins a same-cycle timeout.
        if (Ch_ready[Sel]) begin
          ov_n    = 1'b0;
          ptr_n   = Sel + 2'd1;
          xfer_n  = Xfer_cnt + 1'b1;
          state_n = IDLE;
        end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
          ov_n    = 1'b0;
          drop_n  = 1'b1;
          ptr_n   = Sel + 2'd1;
          dropc_n = Drop_cnt + 1'b1;
          state_n = IDLE;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      In        <= '0;
      Sel       <= '0;
      Out_valid <= 1'b0;
      Drop      <= 1'b0;
      Xfer_cnt  <= '0;
      Drop_cnt  <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      In        <= in_n;
      Sel       <= sel_n;
      Out_valid <= ov_n;
      Drop      <= drop_n;
      Xfer_cnt  <= xfer_n;
      Drop_cnt  <= dropc_n;
      wait_cnt  <= wait_n;
    end
  end

endmodule
